key_stream_gen: RTL and testbench

KEY_STREAM_GEN -- requirements
Module: key_stream_gen

---
 rtl/key_stream_if.sv | 23 ++
 rtl/key_stream_gen.sv | 143 ++++++++++++++
 tb/tb_key_stream_gen.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/key_stream_if.sv
// Handshake bundle between the key stream generator and its seed/consumer side.
// The slave view belongs to the generator; the master view to whoever drives it.
interface key_stream_if #(
  parameter int N = 8
);
  logic         seed_load;
  logic [15:0]  seed;
  logic         enable;
  logic         key_ready;
  logic [N-1:0] key_out;
  logic         key_valid;
  logic         busy;

  modport master (
    output seed_load, seed, enable, key_ready,
    input  key_out, key_valid, busy
  );

  modport slave (
    input  seed_load, seed, enable, key_ready,
    output key_out, key_valid, busy
  );
endinterface

// File: rtl/key_stream_gen.sv
// 16-bit Fibonacci LFSR key stream generator: packs N feedback bits into a word
// and presents it on a valid/ready handshake for the downstream XOR stage.
module key_stream_gen #(
  parameter int          N            = 8,
  parameter logic [15:0] SEED_DEFAULT = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  key_stream_if.slave bus
);

  localparam int              CW    = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0]   LAST  = CW'(N - 1);
  localparam logic [15:0]     TAPS  = 16'h002D;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GEN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_next_state;
  logic [15:0]   r_lfsr;
  logic [N-2:0]  r_ks;
  logic [N-1:0]  r_key_out;
  logic [CW-1:0] r_cnt;
  logic          r_key_valid;
  logic          r_busy;
  logic          w_fb;
  logic          w_last;
  logic [N-1:0]  w_ks_next;

  function automatic logic parity16(input logic [15:0] v);
    return ^v;
  endfunction

  // A zero seed would lock the LFSR, so it is swapped for the default.
  function automatic logic [15:0] seed_sel(input logic [15:0] s);
    return (s == 16'h0000) ? SEED_DEFAULT : s;
  endfunction

  assign w_fb      = parity16(r_lfsr & TAPS);
  assign w_last    = (r_cnt == LAST);
  // r_ks keeps only the N-1 newest bits; the incoming bit completes the word.
  assign w_ks_next = {r_ks, w_fb};

  // Next-state selection; seed_load pre-empts any word in flight.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (bus.seed_load) begin
          w_next_state = IDLE;
        end else if (bus.enable) begin
          w_next_state = GEN;
        end else begin
          w_next_state = IDLE;
        end
      end
      GEN: begin
        if (bus.seed_load) begin
          w_next_state = IDLE;
        end else if (w_last) begin
          w_next_state = HOLD;
        end else begin
          w_next_state = GEN;
        end
      end
      HOLD: begin
        if (bus.seed_load) begin
          w_next_state = IDLE;
        end else if (bus.key_ready) begin
          w_next_state = bus.enable ? GEN : IDLE;
        end else begin
          w_next_state = HOLD;
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // State register, LFSR, shift register, counter and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_lfsr      <= SEED_DEFAULT;
      r_ks        <= '0;
      r_cnt       <= '0;
      r_key_out   <= '0;
      r_key_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_busy  <= (w_next_state == GEN);
      case (r_state)
        IDLE: begin
          if (bus.seed_load) begin
            r_lfsr <= seed_sel(bus.seed);
          end else if (bus.enable) begin
            r_cnt <= '0;
          end
        end
        GEN: begin
          if (bus.seed_load) begin
            r_lfsr      <= seed_sel(bus.seed);
            r_cnt       <= '0;
            r_key_valid <= 1'b0;
          end else begin
            r_lfsr <= {w_fb, r_lfsr[15:1]};
            r_ks   <= w_ks_next[N-2:0];
            if (w_last) begin
              r_key_out   <= w_ks_next;
              r_key_valid <= 1'b1;
              r_cnt       <= '0;
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end
        end
        HOLD: begin
          if (bus.seed_load) begin
            r_lfsr      <= seed_sel(bus.seed);
            r_cnt       <= '0;
            r_key_valid <= 1'b0;
          end else if (bus.key_ready) begin
            r_key_valid <= 1'b0;
          end
        end
        default: begin
          r_key_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.key_out   = r_key_out;
  assign bus.key_valid = r_key_valid;
  assign bus.busy      = r_busy;

endmodule

// File: tb/tb_key_stream_gen.sv
// Scoreboard bench for key_stream_gen: a reference LFSR pushes expected words,
// which are popped and compared whenever key_valid is observed.
`timescale 1ns/1ps
module tb_key_stream_gen;
  localparam int N = 8;

  logic clk = 1'b0;
  logic rst;

  key_stream_if #(.N(N)) bus();

  key_stream_gen #(.N(N), .SEED_DEFAULT(16'hACE1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int           n_checks = 0;
  int           n_errors = 0;
  logic [N-1:0] exp_q[$];
  logic [15:0]  m_lfsr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model of the spec LFSR; first feedback bit lands in the word MSB.
  task automatic model_push();
    logic         fb;
    logic [N-1:0] w;
    w = '0;
    for (int i = 0; i < N; i++) begin
      fb     = m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5];
      m_lfsr = {fb, m_lfsr[15:1]};
      w      = {w[N-2:0], fb};
    end
    exp_q.push_back(w);
  endtask

  task automatic pop_check(input string tag);
    logic [N-1:0] e;
    if (exp_q.size() == 0) begin
      check({tag, "_queue"}, 32'(exp_q.size()), 32'd1);
    end else begin
      e = exp_q.pop_front();
      check(tag, 32'(bus.key_out), 32'(e));
    end
  endtask

  task automatic wait_valid(input string tag, output int cycles);
    cycles = 0;
    do begin
      tick();
      cycles++;
    end while (bus.key_valid !== 1'b1 && cycles < 40);
    check({tag, "_seen"}, 32'(bus.key_valid), 32'd1);
  endtask

  task automatic load_seed(input logic [15:0] s);
    bus.seed_load = 1'b1;
    bus.seed      = s;
    tick();
    bus.seed_load = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int cyc;
    rst           = 1'b1;
    bus.seed_load = 1'b0;
    bus.seed      = 16'h0000;
    bus.enable    = 1'b0;
    bus.key_ready = 1'b0;
    tick();
    tick();
    check("rst_valid", 32'(bus.key_valid), 32'd0);
    check("rst_key",   32'(bus.key_out),   32'h00);
    check("rst_busy",  32'(bus.busy),      32'd0);
    check("rst_lfsr",  32'(dut.r_lfsr),    32'hACE1);
    rst = 1'b0;

    // First word from the default seed
    m_lfsr = 16'hACE1;
    model_push();
    bus.key_ready = 1'b1;
    bus.enable    = 1'b1;
    wait_valid("w1", cyc);
    check("w1_latency", 32'(cyc), 32'd9);
    check("w1_key44",   32'(bus.key_out), 32'h44);
    check("w1_lfsr",    32'(dut.r_lfsr),  32'h22AC);
    pop_check("w1_word");
    bus.enable = 1'b0;
    tick();
    check("w1_valid_drop", 32'(bus.key_valid), 32'd0);
    check("w1_idle_busy",  32'(bus.busy),      32'd0);

    // Zero seed falls back to the default; key_ready in IDLE is ignored
    load_seed(16'h0000);
    check("zs_lfsr",  32'(dut.r_lfsr),    32'hACE1);
    check("zs_valid", 32'(bus.key_valid), 32'd0);
    m_lfsr = 16'hACE1;
    model_push();
    bus.enable = 1'b1;
    wait_valid("zs", cyc);
    check("zs_latency", 32'(cyc), 32'd9);
    check("zs_key44",   32'(bus.key_out), 32'h44);
    pop_check("zs_word");
    bus.enable = 1'b0;
    tick();

    // Back-pressure: word held for 20 cycles with the LFSR frozen
    load_seed(16'hACE1);
    bus.key_ready = 1'b0;
    bus.enable    = 1'b1;
    m_lfsr = 16'hACE1;
    model_push();
    wait_valid("bp", cyc);
    bus.enable = 1'b0;
    pop_check("bp_word");
    for (int i = 0; i < 20; i++) begin
      tick();
      check("bp_valid", 32'(bus.key_valid), 32'd1);
      check("bp_key",   32'(bus.key_out),   32'h44);
      check("bp_lfsr",  32'(dut.r_lfsr),    32'h22AC);
    end
    bus.key_ready = 1'b1;
    tick();
    check("bp_release", 32'(bus.key_valid), 32'd0);
    check("bp_key_kept", 32'(bus.key_out),  32'h44);

    // seed_load during the 4th GEN cycle aborts the word
    load_seed(16'hACE1);
    bus.enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("ab_busy", 32'(bus.busy), 32'd1);
    end
    bus.seed_load = 1'b1;
    bus.seed      = 16'h1234;
    bus.enable    = 1'b0;
    tick();
    bus.seed_load = 1'b0;
    check("ab_valid", 32'(bus.key_valid), 32'd0);
    check("ab_idle",  32'(bus.busy),      32'd0);
    check("ab_lfsr",  32'(dut.r_lfsr),    32'h1234);
    for (int i = 0; i < 12; i++) begin
      tick();
      check("ab_no_valid", 32'(bus.key_valid), 32'd0);
    end
    check("ab_lfsr_hold", 32'(dut.r_lfsr), 32'h1234);

    // Ten back-to-back words at one per N+1 cycles
    load_seed(16'hACE1);
    m_lfsr = 16'hACE1;
    for (int i = 0; i < 10; i++) model_push();
    bus.key_ready = 1'b1;
    bus.enable    = 1'b1;
    for (int w = 0; w < 10; w++) begin
      wait_valid("st", cyc);
      check("st_period", 32'(cyc), 32'd9);
      pop_check("st_word");
      if (w == 9) bus.enable = 1'b0;
    end
    tick();
    check("st_end_valid", 32'(bus.key_valid), 32'd0);
    check("st_end_busy",  32'(bus.busy),      32'd0);

    // Enable dropped after one GEN cycle still completes the word
    bus.enable = 1'b1;
    tick();
    bus.enable = 1'b0;
    model_push();
    wait_valid("dr", cyc);
    check("dr_latency", 32'(cyc), 32'd8);
    pop_check("dr_word");
    tick();
    check("dr_valid_drop", 32'(bus.key_valid), 32'd0);

    // Reset while a word is pending in HOLD
    bus.key_ready = 1'b0;
    bus.enable    = 1'b1;
    model_push();
    wait_valid("rh", cyc);
    bus.enable = 1'b0;
    pop_check("rh_word");
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rh_valid", 32'(bus.key_valid), 32'd0);
    check("rh_key",   32'(bus.key_out),   32'h00);
    check("rh_busy",  32'(bus.busy),      32'd0);
    check("rh_lfsr",  32'(dut.r_lfsr),    32'hACE1);
    m_lfsr = 16'hACE1;
    model_push();
    bus.key_ready = 1'b1;
    bus.enable    = 1'b1;
    wait_valid("rr", cyc);
    check("rr_latency", 32'(cyc), 32'd9);
    check("rr_key44",   32'(bus.key_out), 32'h44);
    pop_check("rr_word");
    bus.enable = 1'b0;
    tick();

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
